// File: rtl/l2_refill_arbiter.sv
// Round-robin arbiter sharing one L2 request/return port between the I-cache (id 0)
// and D-cache (id 1) refill paths, with an in-order owner queue steering return beats.
module l2_refill_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int L2_BUS_WIDTH    = 64,
    parameter int BLOCK_WIDTH     = 128,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enb_i,
    input  logic                    req0_valid_i,
    input  logic [ADDR_WIDTH-1:0]   req0_addr_i,
    output logic                    req0_ready_o,
    input  logic                    req1_valid_i,
    input  logic [ADDR_WIDTH-1:0]   req1_addr_i,
    output logic                    req1_ready_o,
    output logic                    addr_to_l2_valid_o,
    output logic [ADDR_WIDTH-1:0]   addr_to_l2_o,
    input  logic                    addr_to_l2_ready_i,
    input  logic                    data_from_l2_valid_i,
    input  logic [L2_BUS_WIDTH-1:0] data_from_l2_i,
    output logic                    data_from_l2_ready_o,
    output logic                    data0_valid_o,
    output logic [L2_BUS_WIDTH-1:0] data0_o,
    output logic                    data0_last_o,
    input  logic                    data0_ready_i,
    output logic                    data1_valid_o,
    output logic [L2_BUS_WIDTH-1:0] data1_o,
    output logic                    data1_last_o,
    input  logic                    data1_ready_i
);

    localparam int BEATS  = BLOCK_WIDTH / L2_BUS_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W  = PTR_W + 1;

    logic                  addr_valid_q, addr_valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  owner_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  last_grant_q, last_grant_d;

    logic active_s;
    logic slot_free_s;
    logic can_accept_s;
    logic winner_s;
    logic push_s;
    logic nonempty_s;
    logic head_s;
    logic head_ready_s;
    logic xfer_s;
    logic last_beat_s;
    logic pop_s;

    // A full queue blocks acceptance even if a pop lands this cycle: no data->request path.
    assign active_s     = enb_i & ~rst_i;
    assign slot_free_s  = ~addr_valid_q | addr_to_l2_ready_i;
    assign can_accept_s = active_s & slot_free_s & (count_q < CNT_W'(MAX_OUTSTANDING));

    // Round-robin winner: a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        if (req0_valid_i & req1_valid_i) begin
            winner_s = ~last_grant_q;
        end else if (req1_valid_i) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    assign req0_ready_o = can_accept_s & ~winner_s;
    assign req1_ready_o = can_accept_s & winner_s;
    assign push_s       = winner_s ? (req1_valid_i & req1_ready_o)
                                   : (req0_valid_i & req0_ready_o);

    assign addr_to_l2_valid_o = active_s & addr_valid_q;
    assign addr_to_l2_o       = addr_q;

    assign nonempty_s   = (count_q != {CNT_W{1'b0}});
    assign head_s       = owner_q[rd_ptr_q];
    assign head_ready_s = head_s ? data1_ready_i : data0_ready_i;
    assign last_beat_s  = (beat_q == BEAT_W'(BEATS - 1));

    assign data_from_l2_ready_o = active_s & nonempty_s & head_ready_s;
    assign xfer_s               = data_from_l2_valid_i & data_from_l2_ready_o;
    assign pop_s                = xfer_s & last_beat_s;

    assign data0_valid_o = active_s & data_from_l2_valid_i & nonempty_s & ~head_s;
    assign data1_valid_o = active_s & data_from_l2_valid_i & nonempty_s & head_s;
    assign data0_o       = data_from_l2_i;
    assign data1_o       = data_from_l2_i;
    assign data0_last_o  = last_beat_s;
    assign data1_last_o  = last_beat_s;

    // Next state for the address slot, owner-queue pointers/count and beat counter.
    always_comb begin
        addr_d       = addr_q;
        last_grant_d = last_grant_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        addr_valid_d = addr_valid_q;
        beat_d       = beat_q;
        count_d      = count_q;

        if (push_s) begin
            addr_valid_d = 1'b1;
            addr_d       = winner_s ? req1_addr_i : req0_addr_i;
            last_grant_d = winner_s;
            wr_ptr_d     = wr_ptr_q + PTR_W'(1);
        end else if (addr_to_l2_valid_o & addr_to_l2_ready_i) begin
            addr_valid_d = 1'b0;
        end else begin
            addr_valid_d = addr_valid_q;
        end

        if (xfer_s) begin
            if (last_beat_s) begin
                beat_d   = {BEAT_W{1'b0}};
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end else begin
            beat_d = beat_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; enable gating is already folded into push/transfer strobes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_valid_q <= 1'b0;
            addr_q       <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            beat_q       <= {BEAT_W{1'b0}};
            last_grant_q <= 1'b1;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                owner_q[i] <= 1'b0;
            end
        end else begin
            addr_valid_q <= addr_valid_d;
            addr_q       <= addr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            beat_q       <= beat_d;
            last_grant_q <= last_grant_d;
            if (push_s) begin
                owner_q[wr_ptr_q] <= winner_s;
            end else begin
                owner_q[wr_ptr_q] <= owner_q[wr_ptr_q];
            end
        end
    end

endmodule

// File: tb/tb_l2_refill_arbiter.sv
// Bench for l2_refill_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of ownership, beat counting and round-robin grants.
module tb_l2_refill_arbiter;

    localparam int BEATS = 2;
    localparam int MAXO  = 4;

    logic        clk = 1'b0;
    logic        rst, enb, r0v, r1v, ar, dv, d0r, d1r;
    logic [31:0] r0a, r1a;
    logic [63:0] dd;
    logic        r0rdy, r1rdy, av, drdy, d0v, d1v, d0l, d1l;
    logic [31:0] aout;
    logic [63:0] d0, d1;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          mq[$];
    int          mbeat = 0;
    bit          mlg   = 1'b1;
    bit          mav   = 1'b0;
    logic [31:0] maddr = 32'h0;
    bit e_win, e_r0, e_r1, e_av, e_dr, e_d0v, e_d1v, e_last;

    always #5 clk = ~clk;

    l2_refill_arbiter dut (
        .clk_i(clk), .rst_i(rst), .enb_i(enb),
        .req0_valid_i(r0v), .req0_addr_i(r0a), .req0_ready_o(r0rdy),
        .req1_valid_i(r1v), .req1_addr_i(r1a), .req1_ready_o(r1rdy),
        .addr_to_l2_valid_o(av), .addr_to_l2_o(aout), .addr_to_l2_ready_i(ar),
        .data_from_l2_valid_i(dv), .data_from_l2_i(dd), .data_from_l2_ready_o(drdy),
        .data0_valid_o(d0v), .data0_o(d0), .data0_last_o(d0l), .data0_ready_i(d0r),
        .data1_valid_o(d1v), .data1_o(d1), .data1_last_o(d1l), .data1_ready_i(d1r)
    );

    task automatic model_eval();
        bit ok;
        int hd;
        e_win = (r0v && r1v) ? !mlg : (r1v ? 1'b1 : 1'b0);
        ok    = enb && !rst && (!mav || ar) && (mq.size() < MAXO);
        hd    = (mq.size() > 0) ? mq[0] : 0;
        e_r0  = ok && !e_win;
        e_r1  = ok && e_win;
        e_av  = enb && !rst && mav;
        e_dr  = enb && !rst && (mq.size() > 0) && ((hd == 1) ? d1r : d0r);
        e_d0v = enb && !rst && dv && (mq.size() > 0) && (hd == 0);
        e_d1v = enb && !rst && dv && (mq.size() > 0) && (hd == 1);
        e_last = (mbeat == BEATS - 1);
    endtask

    task automatic model_update();
        bit acc, xfer;
        if (rst) begin
            mq.delete();
            mbeat = 0;
            mlg   = 1'b1;
            mav   = 1'b0;
        end else if (enb) begin
            acc  = e_win ? (r1v && e_r1) : (r0v && e_r0);
            xfer = dv && e_dr;
            if (xfer) begin
                if (mbeat == BEATS - 1) begin
                    void'(mq.pop_front());
                    mbeat = 0;
                end else begin
                    mbeat++;
                end
            end
            if (acc) begin
                mq.push_back(e_win ? 1 : 0);
                mav   = 1'b1;
                maddr = e_win ? r1a : r0a;
                mlg   = e_win;
            end else if (mav && ar) begin
                mav = 1'b0;
            end
        end
    endtask

    task automatic drive(input bit i_rst, input bit i_enb,
                         input bit i_r0v, input logic [31:0] i_r0a,
                         input bit i_r1v, input logic [31:0] i_r1a,
                         input bit i_ar, input bit i_dv, input logic [63:0] i_d,
                         input bit i_d0r, input bit i_d1r);
        rst = i_rst; enb = i_enb;
        r0v = i_r0v; r0a = i_r0a; r1v = i_r1v; r1a = i_r1a;
        ar = i_ar; dv = i_dv; dd = i_d; d0r = i_d0r; d1r = i_d1r;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 32'h11, 1'b1, 32'h22, 1'b1, 1'b1, 64'h5, 1'b1, 1'b1);
        total++;
        if ({r0rdy, r1rdy, av, drdy, d0v, d1v} !== 6'b000000) begin
            bad++; $display("FAIL reset_outputs: got %b want 000000", {r0rdy, r1rdy, av, drdy, d0v, d1v});
        end
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h7, 1'b1, 1'b1);
        total++;
        if ({av, drdy, d0v, d1v} !== 4'b0000) begin
            bad++; $display("FAIL idle_after_reset: got %b want 0000", {av, drdy, d0v, d1v});
        end
        tick();
    endtask

    task automatic test_drain();
        logic [63:0] beat;
        for (int i = 0; i < 40 && mq.size() > 0; i++) begin
            beat = {$urandom, $urandom};
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, beat, 1'b1, 1'b1);
            total++;
            if ({drdy, d0v, d1v} !== {e_dr, e_d0v, e_d1v}) begin
                bad++; $display("FAIL drain_route: got %b want %b", {drdy, d0v, d1v}, {e_dr, e_d0v, e_d1v});
            end
            total++;
            if ((e_d0v && (d0l !== e_last || d0 !== beat)) || (e_d1v && (d1l !== e_last || d1 !== beat))) begin
                bad++; $display("FAIL drain_beat: got last0=%b last1=%b want last=%b", d0l, d1l, e_last);
            end
            tick();
        end
        if (mq.size() != 0) begin
            bad++; $display("FAIL drain_timeout: got %0d owners left want 0", mq.size());
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 64'h9, 1'b1, 1'b1);
        total++;
        if ({drdy, d0v, d1v} !== 3'b000) begin
            bad++; $display("FAIL drain_empty: got %b want 000", {drdy, d0v, d1v});
        end
        tick();
    endtask

    task automatic test_tie();
        drive(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        total++;
        if ({r0rdy, r1rdy} !== 2'b10) begin
            bad++; $display("FAIL tie_first: got %b want 10", {r0rdy, r1rdy});
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        total++;
        if ({r0rdy, r1rdy, av} !== 3'b011 || aout !== 32'h100) begin
            bad++; $display("FAIL tie_second: got rdy/av=%b addr=%h want 011 addr=100", {r0rdy, r1rdy, av}, aout);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        total++;
        if (av !== 1'b1 || aout !== 32'h200) begin
            bad++; $display("FAIL tie_addr2: got av=%b addr=%h want 1 addr=200", av, aout);
        end
        tick();
        test_drain();
    endtask

    task automatic test_block();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        total++;
        if ({r0rdy, r1rdy} !== 2'b01) begin
            bad++; $display("FAIL block_grant: got %b want 01", {r0rdy, r1rdy});
        end
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 64'hAAAA_0000_AAAA_0001, 1'b0, 1'b1);
        total++;
        if ({drdy, d0v, d1v, d1l} !== 4'b1010 || d1 !== 64'hAAAA_0000_AAAA_0001) begin
            bad++; $display("FAIL block_beatA: got %b data=%h want 1010", {drdy, d0v, d1v, d1l}, d1);
        end
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 64'hBBBB_0000_BBBB_0002, 1'b0, 1'b1);
        total++;
        if ({drdy, d0v, d1v, d1l} !== 4'b1011 || d1 !== 64'hBBBB_0000_BBBB_0002) begin
            bad++; $display("FAIL block_beatB: got %b data=%h want 1011", {drdy, d0v, d1v, d1l}, d1);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 64'hDEAD, 1'b1, 1'b1);
            total++;
            if ({drdy, d0v, d1v} !== 3'b000) begin
                bad++; $display("FAIL empty_return: got %b want 000", {drdy, d0v, d1v});
            end
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 64'h1234, 1'b1, 1'b0);
        total++;
        if ({d0v, d0l, drdy} !== 3'b101) begin
            bad++; $display("FAIL counter_untouched: got %b want 101", {d0v, d0l, drdy});
        end
        tick();
        test_drain();
    endtask

    task automatic test_full();
        for (int i = 0; i < MAXO; i++) begin
            drive(1'b0, 1'b1, (i % 2 == 0), 32'h1000 + 32'(i), (i % 2 == 1), 32'h2000 + 32'(i),
                  1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
            total++;
            if ({r0rdy, r1rdy} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL fill_grant: got %b at accept %0d", {r0rdy, r1rdy}, i);
            end
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 32'h3000, 1'b1, 32'h4000, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        total++;
        if ({r0rdy, r1rdy} !== 2'b00) begin
            bad++; $display("FAIL full_block: got %b want 00", {r0rdy, r1rdy});
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h3000, 1'b1, 32'h4000, 1'b1, 1'b1, 64'h51, 1'b1, 1'b1);
        total++;
        if ({r0rdy, r1rdy, d0v, d0l} !== 4'b0010) begin
            bad++; $display("FAIL full_beat0: got %b want 0010", {r0rdy, r1rdy, d0v, d0l});
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h3000, 1'b1, 32'h4000, 1'b1, 1'b1, 64'h52, 1'b1, 1'b1);
        total++;
        if ({r0rdy, r1rdy, d0v, d0l} !== 4'b0011) begin
            bad++; $display("FAIL full_pop_same_cycle: got %b want 0011", {r0rdy, r1rdy, d0v, d0l});
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h3000, 1'b1, 32'h4000, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        total++;
        if ({r0rdy, r1rdy} !== 2'b10) begin
            bad++; $display("FAIL after_pop_grant: got %b want 10", {r0rdy, r1rdy});
        end
        tick();
        test_drain();
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 64'hA1, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 64'hB2B2, 1'b1, 1'b0);
            total++;
            if ({drdy, d1v, d1l} !== 3'b011) begin
                bad++; $display("FAIL stall_hold: got %b want 011", {drdy, d1v, d1l});
            end
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 64'hB2B2, 1'b0, 1'b1);
        total++;
        if ({drdy, d1v, d1l} !== 3'b111 || d1 !== 64'hB2B2) begin
            bad++; $display("FAIL stall_resume: got %b data=%h want 111", {drdy, d1v, d1l}, d1);
        end
        tick();
        test_drain();
    endtask

    task automatic test_enb_rst();
        drive(1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 64'hC1, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 1'b1, 64'hC2, 1'b1, 1'b1);
            total++;
            if ({r0rdy, r1rdy, av, drdy, d0v, d1v} !== 6'b000000) begin
                bad++; $display("FAIL enb_off: got %b want 000000", {r0rdy, r1rdy, av, drdy, d0v, d1v});
            end
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 64'hC2, 1'b0, 1'b0);
        total++;
        if ({d0v, d0l, drdy} !== 3'b110) begin
            bad++; $display("FAIL enb_frozen: got %b want 110", {d0v, d0l, drdy});
        end
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'h700, 1'b1, 32'h800, 1'b1, 1'b1, 64'hC3, 1'b1, 1'b1);
        total++;
        if ({r0rdy, r1rdy, av, drdy, d0v, d1v} !== 6'b000000) begin
            bad++; $display("FAIL mid_burst_reset: got %b want 000000", {r0rdy, r1rdy, av, drdy, d0v, d1v});
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h700, 1'b1, 32'h800, 1'b1, 1'b1, 64'hC4, 1'b1, 1'b1);
        total++;
        if ({r0rdy, r1rdy, drdy, d0v, d1v} !== 5'b10000) begin
            bad++; $display("FAIL post_reset_tie: got %b want 10000", {r0rdy, r1rdy, drdy, d0v, d1v});
        end
        tick();
        test_drain();
    endtask

    task automatic test_random();
        bit          b_rst, b_enb;
        logic [63:0] beat;
        for (int i = 0; i < 800; i++) begin
            b_rst = ($urandom_range(0, 59) == 0);
            b_enb = ($urandom_range(0, 7) != 0);
            beat  = {$urandom, $urandom};
            drive(b_rst, b_enb, 1'($urandom), $urandom, 1'($urandom), $urandom,
                  ($urandom_range(0, 3) != 0), 1'($urandom), beat,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
            total++;
            if ({r0rdy, r1rdy, av, drdy, d0v, d1v} !== {e_r0, e_r1, e_av, e_dr, e_d0v, e_d1v}) begin
                bad++; $display("FAIL rand_ctrl: cycle %0d got %b want %b", i,
                                {r0rdy, r1rdy, av, drdy, d0v, d1v}, {e_r0, e_r1, e_av, e_dr, e_d0v, e_d1v});
            end
            if (e_av) begin
                total++;
                if (aout !== maddr) begin
                    bad++; $display("FAIL rand_addr: cycle %0d got %h want %h", i, aout, maddr);
                end
            end
            if (e_d0v || e_d1v) begin
                total++;
                if ((e_d0v && (d0l !== e_last || d0 !== beat)) || (e_d1v && (d1l !== e_last || d1 !== beat))) begin
                    bad++; $display("FAIL rand_beat: cycle %0d got last0=%b last1=%b want %b", i, d0l, d1l, e_last);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; enb = 1'b0; r0v = 1'b0; r1v = 1'b0; r0a = 32'h0; r1a = 32'h0;
        ar = 1'b0; dv = 1'b0; dd = 64'h0; d0r = 1'b0; d1r = 1'b0;
        @(negedge clk);
        test_reset();
        test_tie();
        test_block();
        test_full();
        test_stall();
        test_enb_rst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
